// File: rtl/sprite_frame_scheduler.sv
// Per-frame erase-then-draw sequencer for the sprite blocks, muxing the active sprite onto one VGA write port.
// Build option: define SCHED_TIMEOUT_EN to bound each DRAW wait to DRAW_TIMEOUT cycles and report draw_timeout.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for frame_tick, nothing requested, plot low
// S_ERASE | erase_signal[idx] held for ERASE_CYCLES, then next sprite
// S_DRAW  | draw_signal[idx] held until sprite_finish[idx], then next sprite
module sprite_frame_scheduler #(
    parameter int NUM_SPRITES  = 3,
    parameter int FRAME_DIV    = 833333,
    parameter int ERASE_CYCLES = 44,
    parameter int DRAW_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [9*NUM_SPRITES-1:0]   sprite_x_bus,
    input  logic [8*NUM_SPRITES-1:0]   sprite_y_bus,
    input  logic [3*NUM_SPRITES-1:0]   sprite_colour_bus,
    input  logic [NUM_SPRITES-1:0]     sprite_finish,
    output logic [NUM_SPRITES-1:0]     draw_signal,
    output logic [NUM_SPRITES-1:0]     erase_signal,
    output logic [8:0]                 vga_x,
    output logic [7:0]                 vga_y,
    output logic [2:0]                 vga_colour,
    output logic                       vga_plot,
    output logic                       frame_tick,
    output logic                       busy,
    output logic                       overrun,
    output logic                       draw_timeout
);

    localparam int IW   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int FW   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int CMAX = (ERASE_CYCLES > DRAW_TIMEOUT) ? ERASE_CYCLES : DRAW_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_SPRITES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);
    localparam logic [CW-1:0] ERASE_LAST = CW'(ERASE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DRAW  = 2'd2
    } state_t;

    state_t                 state;
    logic [IW-1:0]          idx;
    logic [CW-1:0]          cnt;
    logic [FW-1:0]          frame_cnt;
    logic [NUM_SPRITES-1:0] sel;
    logic                   fin_sel;
    logic                   timeout_hit;
    logic                   draw_done;

    assign frame_tick = (frame_cnt == FRAME_LAST);

    always_ff @(posedge clk) begin
        if (!reset)
            frame_cnt <= '0;
        else if (frame_tick)
            frame_cnt <= '0;
        else
            frame_cnt <= frame_cnt + FW'(1);
    end

    assign sel     = NUM_SPRITES'(1) << idx;
    assign fin_sel = |(sprite_finish & sel);

`ifdef SCHED_TIMEOUT_EN
    localparam logic [CW-1:0] DRAW_LAST = CW'(DRAW_TIMEOUT - 1);
    // A finish landing on the last allowed cycle wins over the timeout.
    assign timeout_hit = (cnt == DRAW_LAST) && !fin_sel;
`else
    assign timeout_hit  = 1'b0;
    assign draw_timeout = 1'b0;
`endif

    assign draw_done = fin_sel || timeout_hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            cnt     <= '0;
            overrun <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            draw_timeout <= 1'b0;
`endif
        end else begin
            if (frame_tick && (state != S_IDLE))
                overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (frame_tick) begin
                        state <= S_ERASE;
                        idx   <= '0;
                        cnt   <= '0;
                    end
                end
                S_ERASE: begin
                    if (cnt == ERASE_LAST) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            state <= S_DRAW;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DRAW: begin
                    if (draw_done) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            state <= S_IDLE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
`ifdef SCHED_TIMEOUT_EN
                        if (timeout_hit)
                            draw_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                    idx   <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy         = (state != S_IDLE);
    assign vga_plot     = busy;
    assign erase_signal = (state == S_ERASE) ? sel : '0;
    assign draw_signal  = (state == S_DRAW) ? sel : '0;

    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        if (busy) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (idx == IW'(i)) begin
                    vga_x      = sprite_x_bus[9*i +: 9];
                    vga_y      = sprite_y_bus[8*i +: 8];
                    vga_colour = sprite_colour_bus[3*i +: 3];
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Bench for sprite_frame_scheduler: job-queue reference model checked every cycle, plus directed timeline table.
module tb_sprite_frame_scheduler;

    localparam int NS = 3;
    localparam int FD = 400;
    localparam int EC = 44;
    localparam int DT = 64;
    localparam int XW = 9 * NS;
    localparam int YW = 8 * NS;
    localparam int CWB = 3 * NS;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [XW-1:0] sprite_x_bus = '0;
    logic [YW-1:0] sprite_y_bus = '0;
    logic [CWB-1:0] sprite_colour_bus = '0;
    logic [NS-1:0] sprite_finish = '0;
    logic [NS-1:0] draw_signal, erase_signal;
    logic [8:0]    vga_x;
    logic [7:0]    vga_y;
    logic [2:0]    vga_colour;
    logic          vga_plot, frame_tick, busy, overrun, draw_timeout;

    always #5 clk = ~clk;

    sprite_frame_scheduler #(
        .NUM_SPRITES(NS), .FRAME_DIV(FD), .ERASE_CYCLES(EC), .DRAW_TIMEOUT(DT)
    ) dut (
        .clk(clk), .reset(reset),
        .sprite_x_bus(sprite_x_bus), .sprite_y_bus(sprite_y_bus),
        .sprite_colour_bus(sprite_colour_bus), .sprite_finish(sprite_finish),
        .draw_signal(draw_signal), .erase_signal(erase_signal),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .frame_tick(frame_tick), .busy(busy), .overrun(overrun), .draw_timeout(draw_timeout)
    );

    // Reference model: a frame is a queue of jobs (erase each sprite, then draw each sprite).
    typedef struct {
        bit is_draw;
        int spr;
        int n;      // erase: cycles remaining; draw: cycles already spent
    } job_t;

    job_t job_q[$];
    int   fcount, cyc;
    bit   m_ovr, m_tmo, valid;
    int   total, bad;
    int   delay[NS];
    bit   noise, rand_bus, rst_next;

    typedef struct {
        int          cyc;
        logic [NS-1:0] er;
        logic [NS-1:0] dr;
        logic        busy;
        logic        tick;
    } vec_t;

    localparam int NT = 18;
    vec_t tbl[NT];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [NS-1:0] f);
        bit   tick, was_busy;
        job_t j;
        if (r !== 1'b1) begin
            fcount = 0;
            job_q.delete();
            m_ovr = 0;
            m_tmo = 0;
            cyc = 0;
            valid = 1;
        end else begin
            tick = (fcount == FD - 1);
            was_busy = (job_q.size() > 0);
            if (tick && was_busy) m_ovr = 1;
            if (was_busy) begin
                j = job_q[0];
                if (!j.is_draw) begin
                    j.n = j.n - 1;
                    if (j.n == 0) void'(job_q.pop_front());
                    else job_q[0] = j;
                end else if (f[j.spr]) begin
                    void'(job_q.pop_front());
`ifdef SCHED_TIMEOUT_EN
                end else if (j.n == DT - 1) begin
                    void'(job_q.pop_front());
                    m_tmo = 1;
`endif
                end else begin
                    j.n = j.n + 1;
                    job_q[0] = j;
                end
            end
            if (tick && !was_busy) begin
                for (int i = 0; i < NS; i++) job_q.push_back('{1'b0, i, EC});
                for (int i = 0; i < NS; i++) job_q.push_back('{1'b1, i, 0});
            end
            fcount = (fcount + 1) % FD;
            cyc++;
        end
    endtask

    task automatic step();
        logic          r_s;
        logic [NS-1:0] f_s, f;
        logic [NS-1:0] e_er, e_dr;
        logic [8:0]    ex;
        logic [7:0]    ey;
        logic [2:0]    ec;
        int            s;
        @(posedge clk);
        r_s = reset;
        f_s = sprite_finish;
        #1;
        model_edge(r_s, f_s);
        reset = rst_next;
        if (rand_bus) begin
            sprite_x_bus      = XW'($urandom);
            sprite_y_bus      = YW'($urandom);
            sprite_colour_bus = CWB'($urandom);
        end
        f = noise ? NS'($urandom) : '0;
        if (job_q.size() > 0 && job_q[0].is_draw) begin
            s = job_q[0].spr;
            f[s] = (job_q[0].n >= delay[s]);
        end
        sprite_finish = f;
        #1;
        if (valid) begin
            e_er = '0; e_dr = '0; ex = '0; ey = '0; ec = '0;
            if (job_q.size() > 0) begin
                s = job_q[0].spr;
                if (job_q[0].is_draw) e_dr[s] = 1'b1;
                else e_er[s] = 1'b1;
                ex = sprite_x_bus[s*9 +: 9];
                ey = sprite_y_bus[s*8 +: 8];
                ec = sprite_colour_bus[s*3 +: 3];
            end
            chk("erase_signal", erase_signal, e_er);
            chk("draw_signal", draw_signal, e_dr);
            chk("busy", busy, job_q.size() > 0);
            chk("vga_plot", vga_plot, job_q.size() > 0);
            chk("frame_tick", frame_tick, fcount == FD - 1);
            chk("vga_x", vga_x, ex);
            chk("vga_y", vga_y, ey);
            chk("vga_colour", vga_colour, ec);
            chk("overrun", overrun, m_ovr);
            chk("draw_timeout", draw_timeout, m_tmo);
        end
    endtask

    task automatic start_reset();
        rst_next = 0;
        step();
        rst_next = 1;
        step();     // this edge samples reset low: cyc becomes 0
    endtask

    task automatic run_to(input int target);
        for (int c = 0; c < 3000 && cyc != target; c++) step();
        chk("run_to", cyc, target);
    endtask

    task automatic fixed_buses();
        rand_bus = 0;
        sprite_x_bus      = {9'd300, 9'd160, 9'd17};
        sprite_y_bus      = {8'd200, 8'd5, 8'd9};
        sprite_colour_bus = {3'd2, 3'b101, 3'd6};
    endtask

    initial begin
        int k;
        total = 0; bad = 0; valid = 0; cyc = 0; fcount = 0;
        noise = 0; rst_next = 0;
        fixed_buses();

        tbl[0]  = '{0,   3'b000, 3'b000, 1'b0, 1'b0};
        tbl[1]  = '{398, 3'b000, 3'b000, 1'b0, 1'b0};
        tbl[2]  = '{399, 3'b000, 3'b000, 1'b0, 1'b1};
        tbl[3]  = '{400, 3'b001, 3'b000, 1'b1, 1'b0};
        tbl[4]  = '{443, 3'b001, 3'b000, 1'b1, 1'b0};
        tbl[5]  = '{444, 3'b010, 3'b000, 1'b1, 1'b0};
        tbl[6]  = '{487, 3'b010, 3'b000, 1'b1, 1'b0};
        tbl[7]  = '{488, 3'b100, 3'b000, 1'b1, 1'b0};
        tbl[8]  = '{531, 3'b100, 3'b000, 1'b1, 1'b0};
        tbl[9]  = '{532, 3'b000, 3'b001, 1'b1, 1'b0};
        tbl[10] = '{574, 3'b000, 3'b001, 1'b1, 1'b0};
        tbl[11] = '{575, 3'b000, 3'b010, 1'b1, 1'b0};
        tbl[12] = '{617, 3'b000, 3'b010, 1'b1, 1'b0};
        tbl[13] = '{618, 3'b000, 3'b100, 1'b1, 1'b0};
        tbl[14] = '{660, 3'b000, 3'b100, 1'b1, 1'b0};
        tbl[15] = '{661, 3'b000, 3'b000, 1'b0, 1'b0};
        tbl[16] = '{799, 3'b000, 3'b000, 1'b0, 1'b1};
        tbl[17] = '{800, 3'b001, 3'b000, 1'b1, 1'b0};

        // Directed frame timeline: draws finish 42 cycles after request.
        for (int i = 0; i < NS; i++) delay[i] = 42;
        start_reset();
        k = 0;
        for (int c = 0; c < 820 && cyc < 810; c++) begin
            if (c > 0) step();
            if (k < NT && cyc == tbl[k].cyc) begin
                chk("tbl_erase", erase_signal, tbl[k].er);
                chk("tbl_draw", draw_signal, tbl[k].dr);
                chk("tbl_busy", busy, tbl[k].busy);
                chk("tbl_tick", frame_tick, tbl[k].tick);
                k++;
            end
            if (cyc == 300) chk("idle_vga_x", vga_x, 9'd0);
            if (cyc == 300) chk("idle_plot", vga_plot, 1'b0);
            if (cyc == 400) chk("spr0_x", vga_x, 9'd17);
            if (cyc == 444 || cyc == 600) begin
                chk("spr1_x", vga_x, 9'd160);
                chk("spr1_y", vga_y, 8'd5);
                chk("spr1_colour", vga_colour, 3'b101);
            end
            if (cyc == 700) chk("no_overrun", overrun, 1'b0);
        end
        chk("tbl_all", k, NT);

        // Slow draws overrun the frame: tick at 799 is dropped, 1199 starts the next frame.
        for (int i = 0; i < NS; i++) delay[i] = 100;
        start_reset();
        run_to(800);
        chk("ovr_set", overrun, 1'b1);
        chk("ovr_busy", busy, 1'b1);
        run_to(835);
        chk("ovr_idle", busy, 1'b0);
        run_to(1200);
        chk("ovr_next_frame", busy, 1'b1);
        chk("ovr_sticky", overrun, 1'b1);

        // Reset mid-DRAW at sprite 1; frame counter restarts.
        for (int i = 0; i < NS; i++) delay[i] = 42;
        start_reset();
        run_to(591);
        chk("pre_rst_draw", draw_signal, 3'b010);
        rst_next = 0;
        step();
        rst_next = 1;
        step();
        chk("rst_cyc", cyc, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_draw", draw_signal, 3'b000);
        chk("rst_plot", vga_plot, 1'b0);
        chk("rst_vga_x", vga_x, 9'd0);
        run_to(398);
        chk("rst_tick_early", frame_tick, 1'b0);
        step();
        chk("rst_tick", frame_tick, 1'b1);

        // Sprite 2 never finishes.
        delay[0] = 42; delay[1] = 42; delay[2] = 100000;
        start_reset();
        run_to(681);
        chk("stall_draw", draw_signal, 3'b100);
        step();
`ifdef SCHED_TIMEOUT_EN
        chk("tmo_idle", busy, 1'b0);
        chk("tmo_flag", draw_timeout, 1'b1);
`else
        chk("stall_busy", busy, 1'b1);
        chk("stall_draw_held", draw_signal, 3'b100);
        run_to(1300);
        chk("stall_still_busy", busy, 1'b1);
        chk("stall_tmo_zero", draw_timeout, 1'b0);
`endif

        // Random traffic against the model, with finish noise on idle sprites and rare resets.
        noise = 1;
        rand_bus = 1;
        for (int i = 0; i < NS; i++) delay[i] = $urandom_range(0, 70);
        start_reset();
        for (int c = 0; c < 6000; c++) begin
            if (job_q.size() == 0)
                for (int i = 0; i < NS; i++) delay[i] = $urandom_range(0, 70);
            rst_next = ($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_frame_scheduler.md
Name: sprite_frame_scheduler

Overview:
Upstream sequencer for the alien/player sprite blocks. Derives a frame tick from the system clock. Once per frame it erases every sprite in index order, then draws every sprite in index order, driving each sprite's draw_signal/erase_signal. It muxes the selected sprite's x/y/colour onto a single VGA adapter write port with a plot strobe.

Parameters:
NUM_SPRITES, 3, number of sprite blocks scheduled (1..8)
FRAME_DIV, 833333, clk cycles per frame (50 MHz / 60 Hz)
ERASE_CYCLES, 44, cycles erase_signal is held per sprite (covers load + 40-pixel erase)
DRAW_TIMEOUT, 64, max cycles waiting for sprite_finish (used only with SCHED_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
sprite_x_bus  in  9*NUM_SPRITES  packed sprite x; sprite i at [9i+8:9i]
sprite_y_bus  in  8*NUM_SPRITES  packed sprite y; sprite i at [8i+7:8i]
sprite_colour_bus  in  3*NUM_SPRITES  packed sprite colour; sprite i at [3i+2:3i]
sprite_finish  in  NUM_SPRITES  per-sprite draw-complete flag
draw_signal  out  NUM_SPRITES  per-sprite draw request, one-hot or zero
erase_signal  out  NUM_SPRITES  per-sprite erase request, one-hot or zero
vga_x  out  9  selected sprite x
vga_y  out  8  selected sprite y
vga_colour  out  3  selected sprite colour
vga_plot  out  1  VGA write enable
frame_tick  out  1  one-cycle pulse per frame
busy  out  1  high whenever state is not IDLE
overrun  out  1  sticky: a frame tick arrived while busy
draw_timeout  out  1  sticky: a sprite failed to finish within DRAW_TIMEOUT

Behaviour:
- Reset (reset==0 at a posedge clk), including mid-operation:
  - state=IDLE; frame counter, phase counter and idx all =0.
  - All outputs 0, including overrun and draw_timeout.
- Frame counter:
  - Free-running, counts 0..FRAME_DIV-1 and wraps to 0.
  - frame_tick=1 for the single cycle the count equals FRAME_DIV-1.
- States: IDLE, ERASE, DRAW. All outputs are Moore, from registered state, idx and counters.
- IDLE:
  - All request bits 0; vga_plot=0; vga_x/y/colour=0.
  - On frame_tick, next cycle enters ERASE with idx=0, cnt=0.
- ERASE:
  - erase_signal[idx]=1, all other bits 0; vga_plot=1.
  - vga_x/y/colour = slice idx of the input buses.
  - cnt increments each cycle.
  - At cnt==ERASE_CYCLES-1: cnt<=0. If idx==NUM_SPRITES-1, enter DRAW with idx=0; else idx<=idx+1.
- DRAW:
  - draw_signal[idx]=1, held continuously until advance; vga_plot=1; mux as in ERASE.
  - Advance when sprite_finish[idx]==1 is sampled: cnt<=0, draw_signal[idx] drops the next cycle.
  - After the last sprite, return to IDLE.
  - A sprite whose finish is already high on entry advances after exactly one cycle.
- frame_tick while busy: tick is dropped, overrun<=1, and the current frame completes normally. frame_tick in IDLE is never dropped.
- Never more than one bit set across draw_signal|erase_signal.
- idx width is clog2(NUM_SPRITES), minimum 1. Counter widths are sized for their parameters.
- NUM_SPRITES==1: ERASE goes directly to DRAW after ERASE_CYCLES cycles.

Optional Feature:
SCHED_TIMEOUT_EN
- Defined:
  - In DRAW, cnt increments each cycle.
  - If cnt==DRAW_TIMEOUT-1 and sprite_finish[idx]==0, the scheduler advances exactly as on finish and sets draw_timeout<=1 (sticky until reset).
  - Finish in the same cycle as the timeout counts as finish; draw_timeout is not set.
- Undefined:
  - DRAW waits indefinitely for finish.
  - draw_timeout is tied to 0.

Test Plan:
1. NUM_SPRITES=3, FRAME_DIV=400, ERASE_CYCLES=44; release reset; frame_tick first at cycle 399 -> busy rises at cycle 400; erase_signal=001 for 44 cycles, then 010 for 44, then 100 for 44.
2. Same config; each sprite_finish[i] rises 42 cycles after its draw_signal[i] -> draw_signal sequence 001/010/100, each high 43 cycles; busy falls the next cycle; vga_plot low in IDLE; overrun stays 0.
3. Sprite 1 drives x=9'd160, y=8'd5, colour=3'b101 -> those values appear on vga_x/y/colour only while idx==1 and vga_plot==1.
4. FRAME_DIV=100 with draw finishes at 42 cycles -> second frame_tick occurs while busy; overrun=1 and stays 1; the following frame still starts on the next tick seen in IDLE.
5. SCHED_TIMEOUT_EN, DRAW_TIMEOUT=64; sprite 2 never finishes -> draw_signal[2] high exactly 64 cycles, draw_timeout=1, state returns to IDLE; without the macro, busy stays high indefinitely.
6. Assert reset=0 for one cycle mid-DRAW at idx=1 -> next cycle all outputs 0, state IDLE; the frame counter restarts and the next tick lands 400 cycles later.
